// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the adder result pipeline.
// Holds the drain FSM states and the saturating counter helper.
package pipeline_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ACC_WIDTH  = 40;
    localparam int DEF_DEPTH      = 4;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } drain_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == COUNT_MAX) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: rdata presents the head entry with no read latency.
// Exposes full/empty flags and the current occupancy.
module sync_fifo
    import pipeline_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == LVL_FULL);
    assign empty     = (level_r == LVL_ZERO);
    assign level     = level_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    // Stale storage is never exposed: the head reads as zero when empty.
    assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/result_drain.sv
// Captures adder results into a FIFO, keeps running statistics and
// supports a flush that drains the FIFO before clearing the statistics.
module result_drain
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_done,
    input  logic [DATA_WIDTH-1:0] in_sum,
    output logic                  in_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic [ACC_WIDTH-1:0]  acc_sum,
    output logic                  acc_ovf,
    output logic [15:0]           res_count,
    output logic                  drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_ONE = (AW+1)'(1);

    drain_state_t         state_r;
    drain_state_t         state_next_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [AW:0]          fifo_level_s;
    logic                 capture_s;
    logic                 drop_s;
    logic                 pop_s;
    logic                 last_pop_s;
    logic [ACC_WIDTH:0]   acc_add_s;
    logic [ACC_WIDTH-1:0] acc_r;
    logic                 acc_ovf_r;
    logic [15:0]          count_r;
    logic                 drop_err_r;
    logic                 flush_done_r;

    assign in_ready   = (state_r == RUN) && !fifo_full_s;
    assign m_valid    = !fifo_empty_s;
    assign capture_s  = in_done && in_ready;
    assign drop_s     = in_done && !in_ready;
    assign pop_s      = m_valid && m_ready;
    assign last_pop_s = pop_s && (fifo_level_s == LVL_ONE);
    assign acc_add_s  = {1'b0, acc_r} + (ACC_WIDTH+1)'(in_sum);

    assign acc_sum    = acc_r;
    assign acc_ovf    = acc_ovf_r;
    assign res_count  = count_r;
    assign drop_err   = drop_err_r;
    assign flush_done = flush_done_r;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .push  (capture_s),
        .pop   (pop_s),
        .wdata (in_sum),
        .rdata (m_data),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Drain FSM next-state logic; DRAIN leaves as soon as the FIFO is or becomes empty.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (flush_req) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (fifo_empty_s || last_pop_s) begin
                    state_next_s = CLEAR;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            CLEAR:   state_next_s = RUN;
            default: state_next_s = RUN;
        endcase
    end

    // Drain FSM state register and registered completion pulse.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r      <= RUN;
            flush_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            flush_done_r <= (state_next_s == CLEAR);
        end
    end

    // Statistics: cleared on leaving CLEAR, otherwise updated on capture or drop.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc_r      <= {ACC_WIDTH{1'b0}};
            acc_ovf_r  <= 1'b0;
            count_r    <= 16'd0;
            drop_err_r <= 1'b0;
        end else if (state_r == CLEAR) begin
            acc_r      <= {ACC_WIDTH{1'b0}};
            acc_ovf_r  <= 1'b0;
            count_r    <= 16'd0;
            drop_err_r <= 1'b0;
        end else begin
            if (capture_s) begin
                acc_r   <= acc_add_s[ACC_WIDTH-1:0];
                count_r <= sat_inc16(count_r);
                if (acc_add_s[ACC_WIDTH]) begin
                    acc_ovf_r <= 1'b1;
                end
            end
            if (drop_s) begin
                drop_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_result_drain;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AWID  = 40;
    localparam logic [63:0] ACC_MASK = (64'd1 << AWID) - 64'd1;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_CLEAR = 2;

    logic            ap_clk = 1'b0;
    logic            ap_rst = 1'b0;
    logic            in_done = 1'b0;
    logic [DW-1:0]   in_sum = 32'd0;
    logic            in_ready;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic            m_ready = 1'b0;
    logic            flush_req = 1'b0;
    logic            flush_done;
    logic [AWID-1:0] acc_sum;
    logic            acc_ovf;
    logic [15:0]     res_count;
    logic            drop_err;

    logic            ov_done = 1'b0;
    logic [31:0]     ov_sum = 32'd0;
    logic            ov_m_ready = 1'b1;
    logic            ov_flush_req = 1'b0;
    logic            ov_in_ready;
    logic            ov_m_valid;
    logic [31:0]     ov_m_data;
    logic            ov_flush_done;
    logic [31:0]     ov_acc_sum;
    logic            ov_acc_ovf;
    logic [15:0]     ov_res_count;
    logic            ov_drop_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mq[$];
    int          m_mode;
    logic [63:0] m_acc;
    logic        m_ovf;
    int          m_cnt;
    logic        m_drop;

    always #5 ap_clk = ~ap_clk;

    result_drain #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ACC_WIDTH(AWID)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_done(in_done), .in_sum(in_sum),
        .in_ready(in_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .flush_req(flush_req), .flush_done(flush_done), .acc_sum(acc_sum),
        .acc_ovf(acc_ovf), .res_count(res_count), .drop_err(drop_err)
    );

    result_drain #(.DATA_WIDTH(32), .DEPTH(4), .ACC_WIDTH(32)) dut_ovf (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_done(ov_done), .in_sum(ov_sum),
        .in_ready(ov_in_ready), .m_valid(ov_m_valid), .m_data(ov_m_data), .m_ready(ov_m_ready),
        .flush_req(ov_flush_req), .flush_done(ov_flush_done), .acc_sum(ov_acc_sum),
        .acc_ovf(ov_acc_ovf), .res_count(ov_res_count), .drop_err(ov_drop_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = M_RUN;
        m_acc  = 64'd0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
        m_drop = 1'b0;
    endtask

    // Advance the reference model by one clock using the inputs currently driven.
    task automatic model_step();
        int  old_mode;
        bit  ready;
        bit  pop;
        bit  cap;
        logic [63:0] total;
        old_mode = m_mode;
        ready = (m_mode == M_RUN) && (mq.size() < DEPTH);
        pop   = (mq.size() > 0) && m_ready;
        cap   = in_done && ready;
        if (pop) void'(mq.pop_front());
        if (cap) mq.push_back(in_sum);
        if (old_mode == M_RUN) begin
            if (flush_req) m_mode = M_DRAIN;
        end else if (old_mode == M_DRAIN) begin
            if (mq.size() == 0) m_mode = M_CLEAR;
        end else begin
            m_mode = M_RUN;
        end
        if (old_mode == M_CLEAR) begin
            m_acc = 64'd0; m_ovf = 1'b0; m_cnt = 0; m_drop = 1'b0;
        end else begin
            if (cap) begin
                total = m_acc + {32'd0, in_sum};
                if (total > ACC_MASK) m_ovf = 1'b1;
                m_acc = total & ACC_MASK;
                if (m_cnt < 65535) m_cnt++;
            end
            if (in_done && !ready) m_drop = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] head;
        head = (mq.size() > 0) ? mq[0] : 32'd0;
        check_eq({tag, ".in_ready"}, in_ready, ((m_mode == M_RUN) && (mq.size() < DEPTH)));
        check_eq({tag, ".m_valid"}, m_valid, (mq.size() > 0));
        check_eq({tag, ".m_data"}, m_data, head);
        check_eq({tag, ".flush_done"}, flush_done, (m_mode == M_CLEAR));
        check_eq({tag, ".acc_sum"}, acc_sum, m_acc);
        check_eq({tag, ".acc_ovf"}, acc_ovf, m_ovf);
        check_eq({tag, ".res_count"}, res_count, 64'(m_cnt));
        check_eq({tag, ".drop_err"}, drop_err, m_drop);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge ap_clk);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        in_done = 1'b0; flush_req = 1'b0; m_ready = 1'b0; ov_done = 1'b0;
        #2;
        model_reset();
        compare_all("rst");
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        compare_all("rst_rel");
        check_eq("rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] vals [3];
        bit seen;
        vals[0] = 32'd5; vals[1] = 32'd7; vals[2] = 32'd9;
        #1;
        do_reset();

        // Three captures with a consumer always ready.
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_done = 1'b1; in_sum = vals[i];
            tick("seq");
            check_eq("seq_head", m_data, vals[i]);
        end
        in_done = 1'b0;
        tick("seq_end");
        check_eq("seq_acc21", acc_sum, 64'd21);
        check_eq("seq_cnt3", res_count, 64'd3);

        // Fill to full with no consumer, then overflow once.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_done = 1'b1; in_sum = $urandom();
            tick("fill");
            if (i == 3) check_eq("full_in_ready", in_ready, 1'b0);
        end
        check_eq("full_drop", drop_err, 1'b1);
        check_eq("full_cnt4", res_count, 64'd4);

        // Pop and done in the same cycle while full: only the next cycle captures.
        m_ready = 1'b1; in_done = 1'b1; in_sum = 32'hA5A5_0001;
        tick("full_pop");
        check_eq("full_pop_cnt", res_count, 64'd4);
        in_sum = 32'hA5A5_0002;
        tick("after_pop");
        check_eq("after_pop_cnt", res_count, 64'd5);
        in_done = 1'b0;

        // Flush with three entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_done = 1'b1; in_sum = 32'h100 + 32'(i);
            tick("pre_flush");
        end
        in_done = 1'b0; flush_req = 1'b1; m_ready = 1'b1;
        tick("flush0");
        flush_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick("drain");
            if (flush_done) seen = 1'b1;
        end
        check_eq("flush_seen", seen, 1'b1);
        tick("post_flush");
        check_eq("post_flush_acc", acc_sum, 64'd0);
        check_eq("post_flush_cnt", res_count, 64'd0);
        check_eq("post_flush_rdy", in_ready, 1'b1);

        // Reset while draining with two entries held.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            in_done = 1'b1; in_sum = $urandom();
            tick("pre_rst");
        end
        in_done = 1'b0; flush_req = 1'b1;
        tick("drain_hold");
        flush_req = 1'b0;
        tick("drain_hold2");
        do_reset();
        check_eq("mid_rst_mvalid", m_valid, 1'b0);
        for (int i = 0; i < 3; i++) tick("post_rst");

        // Accumulator carry-out on the narrow-accumulator instance.
        do_reset();
        ov_done = 1'b1; ov_sum = 32'hFFFF_FFFF;
        tick("ovf0");
        tick("ovf1");
        ov_done = 1'b0;
        check_eq("ovf_acc", ov_acc_sum, 64'hFFFF_FFFE);
        check_eq("ovf_flag", ov_acc_ovf, 1'b1);
        check_eq("ovf_cnt", ov_res_count, 64'd2);
        check_eq("ovf_rdy", ov_in_ready, 1'b1);
        check_eq("ovf_mvalid", ov_m_valid, 1'b1);
        check_eq("ovf_mdata", ov_m_data, 64'hFFFF_FFFF);
        check_eq("ovf_fdone", ov_flush_done, 1'b0);
        check_eq("ovf_drop", ov_drop_err, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            in_done   = ($urandom_range(0, 1) == 1);
            in_sum    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
            m_ready   = ($urandom_range(0, 9) < 6);
            flush_req = ($urandom_range(0, 29) == 0);
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
